// File: rtl/cordic_atan2_ctrl.sv
// -----------------------------------------------------------------------------
// cordic_atan2_ctrl
//
// Front-end and sequencer for a 32-bit iterative vectoring CORDIC core.
// A signed (x, y) sample is accepted over a valid/ready handshake. It is
// pre-rotated into the right half-plane and magnitude-normalised so the core
// converges at full precision without overflow. The core is then started and
// its ITER iterations are waited out. The full-range atan2 phase (-pi..pi,
// Q3.29) is returned over a valid/ready handshake.
//
// Ports
//   clk         clock, all logic on rising edge
//   rst         asynchronous, active-high reset
//   in_valid    input sample valid
//   in_ready    high only while idle
//   in_x, in_y  signed integer coordinates, full 32-bit range
//   core_start  one-cycle start pulse to the core
//   core_x/y    normalised core operands (x >= 0), stable from START to CAPTURE
//   core_phi    core angle, Q2.30 radians
//   out_valid   result valid
//   out_ready   consumer accepts result
//   out_phase   signed Q3.29 radians, range [-pi, pi]
// -----------------------------------------------------------------------------
module cordic_atan2_ctrl #(
  parameter int          ITER     = 28,
  parameter logic [31:0] PI_Q329  = 32'h6487ED51
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  output logic        core_start,
  output logic [31:0] core_x,
  output logic [31:0] core_y,
  input  logic [31:0] core_phi,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_phase
);

  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    START,
    WAIT,
    CAPTURE,
    OUT
  } state_t;

  state_t state_q, state_d;

  // 33-bit working copies: negating -2^31 needs the extra bit.
  logic signed [32:0] xn_q, yn_q;
  logic signed [31:0] quad_q;
  logic               zero_q;
  logic [CNT_W-1:0]   cnt_q;

  // Magnitude test for normalisation. OR-ing the magnitudes gives the
  // position of the larger leading one without a comparator.
  logic [32:0] ax, ay, m;
  logic        m_zero, m_big, m_small, norm_done;

  assign ax        = xn_q[32] ? -xn_q : xn_q;
  assign ay        = yn_q[32] ? -yn_q : yn_q;
  assign m         = ax | ay;
  assign m_zero    = ~|m;
  assign m_big     = |m[32:29];        // m >= 2^29
  assign m_small   = ~|m[32:28];       // m <  2^28
  assign norm_done = m_zero || (!m_big && !m_small);

  logic signed [31:0] phi_s;
  assign phi_s = $signed(core_phi);

  assign in_ready   = (state_q == IDLE);
  assign core_start = (state_q == START);

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)                      state_d = NORM;
      NORM:    if (norm_done)                     state_d = START;
      START:                                      state_d = WAIT;
      WAIT:    if (cnt_q == CNT_W'(ITER - 1))     state_d = CAPTURE;
      CAPTURE:                                    state_d = OUT;
      OUT:     if (out_ready)                     state_d = IDLE;
      default:                                    state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      xn_q      <= '0;
      yn_q      <= '0;
      quad_q    <= '0;
      zero_q    <= 1'b0;
      cnt_q     <= '0;
      core_x    <= '0;
      core_y    <= '0;
      out_valid <= 1'b0;
      out_phase <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            zero_q <= (in_x == 32'd0) && (in_y == 32'd0);
            if (in_x[31]) begin
              // Left half-plane: rotate by pi; the sign of y picks which
              // side of the branch cut the result lands on.
              xn_q   <= -$signed({in_x[31], in_x});
              yn_q   <= -$signed({in_y[31], in_y});
              quad_q <= in_y[31] ? -$signed(PI_Q329) : $signed(PI_Q329);
            end else begin
              xn_q   <= $signed({in_x[31], in_x});
              yn_q   <= $signed({in_y[31], in_y});
              quad_q <= '0;
            end
          end
        end
        NORM: begin
          if (norm_done) begin
            // Normalised magnitudes are below 2^29, so the low 32 bits
            // carry the full value.
            core_x <= xn_q[31:0];
            core_y <= yn_q[31:0];
          end else if (m_big) begin
            xn_q <= xn_q >>> 1;
            yn_q <= yn_q >>> 1;
          end else begin
            xn_q <= xn_q <<< 1;
            yn_q <= yn_q <<< 1;
          end
        end
        START: cnt_q <= '0;
        WAIT:  cnt_q <= cnt_q + CNT_W'(1);
        CAPTURE: begin
          // Q2.30 -> Q3.29, then undo the pre-rotation. |phi| <= pi/2 so
          // the sum stays within [-pi, pi].
          out_phase <= zero_q ? 32'd0 : 32'(($signed(phi_s) >>> 1) + quad_q);
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_atan2_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cordic_atan2_ctrl
//
// Directed bench for cordic_atan2_ctrl. A behavioural core stands in for the
// real CORDIC: it latches core_x/core_y on core_start and presents the ideal
// atan2 angle (Q2.30) exactly ITER cycles later, showing a junk pattern until
// then. A zero vector yields the sum of all rotation angles, as a real
// vectoring core would.
// -----------------------------------------------------------------------------
module tb_cordic_atan2_ctrl;

  localparam int ITER = 28;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x, in_y;
  logic        core_start;
  logic [31:0] core_x, core_y;
  logic [31:0] core_phi;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_phase;

  int checks = 0;
  int errors = 0;

  cordic_atan2_ctrl #(.ITER(ITER), .PI_Q329(32'h6487ED51)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .core_start (core_start),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_phi   (core_phi),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_phase  (out_phase)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural core ----------------
  logic signed [31:0] m_x = '0, m_y = '0;
  int                 m_cnt = 0;
  logic               m_busy = 1'b0;
  int                 start_count = 0;
  logic [31:0]        start_x = '0, start_y = '0;

  function automatic logic [31:0] ideal_phi(input logic signed [31:0] x,
                                            input logic signed [31:0] y);
    int acc;
    real a;
    if (x == 0 && y == 0) begin
      acc = 0;
      for (int i = 0; i < ITER; i++) acc += int'($atan(2.0 ** (-i)) * 1073741824.0);
      return acc;
    end
    a = $atan2(real'(y), real'(x));
    return int'(a * 1073741824.0);
  endfunction

  always @(posedge clk) begin
    if (core_start === 1'b1) begin
      m_x         <= core_x;
      m_y         <= core_y;
      m_cnt       <= 0;
      m_busy      <= 1'b1;
      core_phi    <= 32'h5A5A5A5A;
      start_count <= start_count + 1;
      start_x     <= core_x;
      start_y     <= core_y;
    end else if (m_busy) begin
      if (m_cnt == ITER - 1) begin
        core_phi <= ideal_phi(m_x, m_y);
        m_busy   <= 1'b0;
      end else begin
        core_phi <= 32'h5A5A5A5A ^ 32'(m_cnt);
      end
      m_cnt <= m_cnt + 1;
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  // Waits for out_valid; lat counts rising edges since the accepting edge.
  task automatic wait_out(output int lat, output logic [31:0] ph);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    ph = out_phase;
  endtask

  // Called #1 after a rising edge with the DUT idle. Completes the output
  // handshake too when out_ready is high.
  task automatic send_sample(input logic [31:0] x, input logic [31:0] y,
                             output int lat, output logic [31:0] ph);
    in_x = x; in_y = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat, ph);
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (core_start !== 1'b0)  begin errors++; $display("FAIL reset_core_start got %b want 0", core_start); end
    checks++; if (core_x !== 32'd0)     begin errors++; $display("FAIL reset_core_x got %h want 0", core_x); end
    checks++; if (core_y !== 32'd0)     begin errors++; $display("FAIL reset_core_y got %h want 0", core_y); end
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_phase !== 32'd0)  begin errors++; $display("FAIL reset_out_phase got %h want 0", out_phase); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_diag;
    int lat; logic [31:0] ph; int d;
    send_sample(32'h00100000, 32'h00100000, lat, ph);
    d = int'($signed(ph - 32'h1921FB54));
    checks++; if (lat != 39)         begin errors++; $display("FAIL diag_latency got %0d want 39", lat); end
    checks++; if (d > 4 || d < -4)   begin errors++; $display("FAIL diag_phase got %h want 1921fb54+-4", ph); end
    checks++; if (start_x !== 32'h10000000 || start_y !== 32'h10000000)
      begin errors++; $display("FAIL diag_norm got %h,%h want 10000000,10000000", start_x, start_y); end
  endtask

  task automatic test_axes;
    int lat; logic [31:0] ph; int d;
    send_sample(32'hFFF00000, 32'h00000000, lat, ph);
    d = int'($signed(ph - 32'h6487ED51));
    checks++; if (d > 4 || d < -4)   begin errors++; $display("FAIL neg_x_axis_phase got %h want 6487ed51+-4", ph); end
    checks++; if (lat != 39)         begin errors++; $display("FAIL neg_x_axis_latency got %0d want 39", lat); end
    send_sample(32'h00000000, 32'hFFF00000, lat, ph);
    d = int'($signed(ph - 32'hCDBC0957));
    checks++; if (d > 4 || d < -4)   begin errors++; $display("FAIL neg_y_axis_phase got %h want cdbc0957+-4", ph); end
  endtask

  task automatic test_min_neg;
    int lat; logic [31:0] ph; int d;
    send_sample(32'h80000000, 32'h80000000, lat, ph);
    d = int'($signed(ph - 32'hB49A0E03));
    checks++; if (lat != 34)         begin errors++; $display("FAIL min_neg_latency got %0d want 34", lat); end
    checks++; if (d > 4 || d < -4)   begin errors++; $display("FAIL min_neg_phase got %h want b49a0e03+-4", ph); end
    checks++; if (start_x !== 32'h10000000 || start_y !== 32'h10000000)
      begin errors++; $display("FAIL min_neg_norm got %h,%h want 10000000,10000000", start_x, start_y); end
  endtask

  task automatic test_zero;
    int lat; logic [31:0] ph;
    send_sample(32'h0, 32'h0, lat, ph);
    checks++; if (lat != 31)         begin errors++; $display("FAIL zero_latency got %0d want 31", lat); end
    checks++; if (ph !== 32'd0)      begin errors++; $display("FAIL zero_phase got %h want 0", ph); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] ph, held; int d; int starts0;
    out_ready = 1'b0;
    send_sample(32'h00100000, 32'h00100000, lat, held);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_timeout out_valid got %b want 1", out_valid); end
    // A competing sample is offered during the stall and must be ignored.
    in_x = 32'h00000000; in_y = 32'h00100000; in_valid = 1'b1;
    starts0 = start_count;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid cycle %0d got %b want 1", i, out_valid); end
      checks++; if (out_phase !== held) begin errors++; $display("FAIL stall_out_phase cycle %0d got %h want %h", i, out_phase, held); end
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL stall_in_ready cycle %0d got %b want 0", i, in_ready); end
    end
    checks++; if (start_count != starts0) begin errors++; $display("FAIL stall_core_start got %0d pulses want 0", start_count - starts0); end
    out_ready = 1'b1;
    @(posedge clk); #1;                       // output handshake edge
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL handshake_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL handshake_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;                       // accepting edge
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL next_accept in_ready got %b want 0", in_ready); end
    wait_out(lat, ph);
    d = int'($signed(ph - 32'h3243F6A8));
    checks++; if (lat != 39)          begin errors++; $display("FAIL next_latency got %0d want 39", lat); end
    checks++; if (d > 4 || d < -4)    begin errors++; $display("FAIL next_phase got %h want 3243f6a8+-4", ph); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] ph; int d; bit spurious;
    in_x = 32'h00100000; in_y = 32'h00100000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);               // well inside WAIT
    #1 rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL midrst_core_start got %b want 0", core_start); end
    checks++; if (core_x !== 32'd0 || core_y !== 32'd0)
      begin errors++; $display("FAIL midrst_core_xy got %h,%h want 0,0", core_x, core_y); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if (out_phase !== 32'd0) begin errors++; $display("FAIL midrst_out_phase got %h want 0", out_phase); end
    @(posedge clk); #1;
    rst = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || core_start !== 1'b0) spurious = 1'b1;
    end
    checks++; if (spurious) begin errors++; $display("FAIL midrst_spurious got activity want none"); end
    send_sample(32'h00100000, 32'h00000000, lat, ph);
    d = int'($signed(ph));
    checks++; if (lat != 39)         begin errors++; $display("FAIL post_rst_latency got %0d want 39", lat); end
    checks++; if (d > 4 || d < -4)   begin errors++; $display("FAIL post_rst_phase got %h want 0+-4", ph); end
  endtask

  initial begin
    test_reset;
    test_diag;
    test_axes;
    test_min_neg;
    test_zero;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
